// File: rtl/instruction_sequencer_pkg.sv
// rtl/instruction_sequencer_pkg.sv - shared state, instruction-field and program-entry definitions
package instruction_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } seq_state_t;

  localparam int INSTR_W    = 6;
  localparam int ACT_LO     = 0;
  localparam int NN_START   = 2;
  localparam int LOAD_IN    = 3;
  localparam int LOAD_W     = 4;
  localparam int LOAD_B     = 5;
  localparam int HOLD_W_DEF = 8;

  typedef struct packed {
    logic [HOLD_W_DEF-1:0] hold_count;
    logic [INSTR_W-1:0]    instr;
  } prog_entry_t;

  function automatic logic [INSTR_W-1:0] make_instr(input logic [1:0] act, input logic nn,
                                                    input logic li, input logic lw, input logic lb);
    logic [INSTR_W-1:0] w;
    w              = '0;
    w[ACT_LO +: 2] = act;
    w[NN_START]    = nn;
    w[LOAD_IN]     = li;
    w[LOAD_W]      = lw;
    w[LOAD_B]      = lb;
    return w;
  endfunction

endpackage

// File: rtl/instruction_sequencer_hold_counter.sv
// rtl/instruction_sequencer_hold_counter.sv - per-entry hold counter (load/decrement/expire)
module seq_hold_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             expire
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] count;

  // A zero hold loads as one, and decrement saturates at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= (load_val == '0) ? ONE : load_val;
    end else if (dec && (count > ONE)) begin
      count <= count - ONE;
    end
  end

  assign expire = (count <= ONE);

endmodule

// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - issues held instruction words from a small program memory
module instruction_sequencer
  import instruction_sequencer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               prog_we,
  input  logic [AW-1:0]      prog_addr,
  input  logic [CNT_W+5:0]   prog_data,
  input  logic [AW:0]        prog_len,
  input  logic               start,
  input  logic               stall,
  input  logic               abort,
  output logic [INSTR_W-1:0] instruction,
  output logic [AW-1:0]      pc,
  output logic               busy,
  output logic               done
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  seq_state_t         state_q, state_d;
  logic [AW-1:0]      pc_q, pc_d, rd_addr;
  logic [AW:0]        len_q, len_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [CNT_W+5:0]   mem [DEPTH];
  logic [CNT_W+5:0]   rd_entry;
  logic               cnt_clr, cnt_load, cnt_dec, expire;

  always_ff @(posedge clk) begin
    if (prog_we && (state_q == IDLE)) mem[prog_addr] <= prog_data;
  end

  // Forward a same-cycle IDLE write so write+start sees the new entry 0.
  assign rd_entry = (prog_we && (state_q == IDLE) && (prog_addr == rd_addr)) ? prog_data : mem[rd_addr];

  seq_hold_counter #(.CNT_W(CNT_W)) u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (rd_entry[CNT_W+5:6]),
    .dec      (cnt_dec),
    .expire   (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    len_d    = len_q;
    instr_d  = instr_q;
    rd_addr  = '0;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    if (abort) begin
      state_d = IDLE;
      pc_d    = '0;
      instr_d = '0;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          pc_d    = '0;
          instr_d = '0;
          if (start) begin
            if ((prog_len != '0) && (prog_len <= DEPTH_L)) begin
              state_d  = RUN;
              len_d    = prog_len;
              cnt_load = 1'b1;
              instr_d  = rd_entry[5:0];
            end else begin
              state_d = FIN;
            end
          end
        end
        RUN: begin
          rd_addr = pc_q + AW'(1);
          if (!stall) begin
            if (!expire) begin
              cnt_dec = 1'b1;
            end else if (({1'b0, pc_q} + (AW+1)'(1)) < len_q) begin
              pc_d     = pc_q + AW'(1);
              cnt_load = 1'b1;
              instr_d  = rd_entry[5:0];
            end else begin
              state_d = FIN;
              instr_d = '0;
              cnt_clr = 1'b1;
            end
          end
        end
        FIN: begin
          state_d = IDLE;
          instr_d = '0;
        end
        default: begin
          state_d = IDLE;
          pc_d    = '0;
          instr_d = '0;
        end
      endcase
    end
  end

  assign instruction = instr_q;
  assign pc          = pc_q;
  assign busy        = (state_q == RUN);
  assign done        = (state_q == FIN);

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb/tb_instruction_sequencer.sv - directed and randomized checks of instruction_sequencer
module tb_instruction_sequencer;
  import instruction_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [13:0] prog_data;
  logic [4:0]  prog_len;
  logic        start, stall, abort;
  logic [5:0]  instruction;
  logic [3:0]  pc;
  logic        busy, done;

  int errors = 0;
  int checks = 0;
  prog_entry_t model_mem [16];

  instruction_sequencer #(.DEPTH(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_len(prog_len), .start(start), .stall(stall),
    .abort(abort), .instruction(instruction), .pc(pc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input logic exp_done);
    check({tag, "_instr"}, 32'(instruction), 32'(0));
    check({tag, "_busy"},  32'(busy),        32'(0));
    check({tag, "_done"},  32'(done),        32'(exp_done));
  endtask

  task automatic write_entry(input int addr, input int hold, input logic [5:0] ins);
    prog_entry_t e;
    e.hold_count = 8'(hold);
    e.instr      = ins;
    prog_we   = 1'b1;
    prog_addr = 4'(addr);
    prog_data = e;
    tick();
    prog_we   = 1'b0;
    model_mem[addr] = e;
  endtask

  // Expected trace: each entry expands to max(hold,1) slots; a stalled cycle repeats the slot.
  task automatic run_model(input int len, input int stall_pct, input bit noise);
    int slot_instr[$];
    int slot_pc[$];
    int idx, cyc, h;
    bit s;
    for (int i = 0; i < len; i++) begin
      h = (model_mem[i].hold_count == 0) ? 1 : int'(model_mem[i].hold_count);
      for (int k = 0; k < h; k++) begin
        slot_instr.push_back(int'(model_mem[i].instr));
        slot_pc.push_back(i);
      end
    end
    prog_len = 5'(len);
    start    = 1'b1;
    tick();
    start = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < slot_instr.size() && cyc < 2000) begin
      check("run_instr", 32'(instruction), 32'(slot_instr[idx]));
      check("run_pc",    32'(pc),          32'(slot_pc[idx]));
      check("run_busy",  32'(busy),        32'(1));
      check("run_done",  32'(done),        32'(0));
      s = ($urandom_range(99) < stall_pct);
      stall = s;
      if (noise) begin
        prog_len  = 5'($urandom_range(31));
        start     = 1'($urandom_range(1));
        prog_we   = 1'($urandom_range(1));
        prog_addr = 4'($urandom_range(15));
        prog_data = 14'($urandom);
      end
      tick();
      stall   = 1'b0;
      start   = 1'b0;
      prog_we = 1'b0;
      if (!s) idx++;
      cyc++;
    end
    check("run_bound", 32'(idx), 32'(slot_instr.size()));
    check_idle("run_fin", 1'b1);
    tick();
    check_idle("run_after", 1'b0);
  endtask

  initial begin
    int len;
    rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    prog_len = '0; start = 1'b0; stall = 1'b0; abort = 1'b0;
    #1;
    check_idle("reset", 1'b0);
    check("reset_pc", 32'(pc), 32'(0));
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Two-entry program with explicit cycle expectations.
    write_entry(0, 3, make_instr(2'd0, 1'b0, 1'b1, 1'b1, 1'b0));
    write_entry(1, 1, make_instr(2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    prog_len = 5'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check("basic_e0", 32'(instruction), 32'h18);
      check("basic_pc0", 32'(pc), 32'(0));
      check("basic_busy", 32'(busy), 32'(1));
      tick();
    end
    check("basic_e1", 32'(instruction), 32'h04);
    check("basic_pc1", 32'(pc), 32'(1));
    tick();
    check_idle("basic_fin", 1'b1);
    tick();
    check_idle("basic_idle", 1'b0);

    // Stall stretches a single 4-cycle entry to 6 cycles.
    write_entry(0, 4, make_instr(2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    prog_len = 5'd1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      check("stall_instr", 32'(instruction), 32'h20);
      check("stall_pc", 32'(pc), 32'(0));
      check("stall_done", 32'(done), 32'(0));
      stall = (c == 2 || c == 3);
      tick();
      stall = 1'b0;
    end
    check_idle("stall_fin", 1'b1);
    tick();
    check_idle("stall_idle", 1'b0);

    // Zero hold counts as one; empty and oversized lengths finish without running.
    write_entry(0, 0, 6'h0C);
    prog_len = 5'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check("hold0_instr", 32'(instruction), 32'h0C);
    tick();
    check_idle("hold0_fin", 1'b1);
    tick();
    prog_len = 5'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check_idle("len0_fin", 1'b1);
    tick();
    check_idle("len0_idle", 1'b0);
    prog_len = 5'd17; start = 1'b1;
    tick();
    start = 1'b0;
    check_idle("len17_fin", 1'b1);
    tick();

    // Abort during entry 1, then re-run from the top.
    write_entry(0, 2, 6'h01);
    write_entry(1, 2, 6'h22);
    write_entry(2, 2, 6'h13);
    prog_len = 5'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    check("abort_pre_instr", 32'(instruction), 32'h22);
    check("abort_pre_pc", 32'(pc), 32'(1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("abort_next", 1'b0);
    check("abort_pc", 32'(pc), 32'(0));
    tick();
    check_idle("abort_later", 1'b0);
    run_model(3, 0, 1'b0);

    // Write and start in the same IDLE cycle use the new entry.
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = {8'd1, 6'h2A};
    prog_len = 5'd1; start = 1'b1;
    tick();
    prog_we = 1'b0; start = 1'b0;
    model_mem[0] = {8'd1, 6'h2A};
    check("wstart_instr", 32'(instruction), 32'h2A);
    tick();
    check_idle("wstart_fin", 1'b1);
    tick();

    // Asynchronous reset mid-run; memory survives and the run does not resume.
    write_entry(0, 3, 6'h11);
    write_entry(1, 2, 6'h07);
    write_entry(2, 1, 6'h30);
    prog_len = 5'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    check_idle("rst_mid", 1'b0);
    check("rst_mid_pc", 32'(pc), 32'(0));
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check_idle("rst_noresume", 1'b0);
    run_model(3, 20, 1'b0);

    // Full-depth program.
    for (int i = 0; i < 16; i++) write_entry(i, int'($urandom_range(2)), 6'($urandom));
    run_model(16, 10, 1'b1);

    // Randomized programs with writes, starts and length changes thrown at the run.
    for (int it = 0; it < 8; it++) begin
      len = int'($urandom_range(1, 6));
      for (int i = 0; i < len; i++) write_entry(i, int'($urandom_range(3)), 6'($urandom));
      run_model(len, 25, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
